wb_burst_traffic_gen: RTL
=========================

Name: wb_burst_traffic_gen

Overview:
- Parametrised Wishbone B3 burst master for exercising the SDRAM controller's Wishbone port (dw-wide data, APP_AW address).
- Issues incrementing-address bursts (CTI 3'b010/3'b111) of programmable length.
- Optionally reads the same bursts back and self-checks them against a deterministic data pattern.
- Sits between the bench sequencer (start/config) and the controller's wb_* slave port; replaces ad-hoc single-beat bus driving.

Parameters:
- dw, 32, Wishbone data width in bits; multiple of 8, 8..128.
- APP_AW, 26, Wishbone address width in bits (byte address).
- MAX_BL_W, 8, width of burst-length field; max burst length 2**MAX_BL_W beats.
- TO_CYCLES, 1024, ack timeout in cycles; used only with the optional feature.

Ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request to run a sequence; sampled only in IDLE.
- mode_i  in  2  00 write then read-check; 01 write only; 10 read-check only; 11 reserved, treated as 00.
- base_addr_i  in  APP_AW  byte address of first beat; captured on accepted start.
- burst_len_i  in  MAX_BL_W  beats per burst; 0 means 2**MAX_BL_W.
- seed_i  in  dw  pattern seed; captured on accepted start.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse when the sequence completes or aborts.
- err_cnt_o  out  16  read-beat mismatch count; saturates at 16'hFFFF.
- first_err_addr_o  out  APP_AW  address of the first mismatching beat.
- timeout_o  out  1  sticky abort flag; constant 0 when the feature is compiled out.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master strobes.
- wb_addr_o  out  APP_AW  beat address.
- wb_dat_o  out  dw  write data.
- wb_sel_o  out  dw/8  byte selects.
- wb_cti_o  out  3  cycle type identifier.
- wb_ack_i  in  1  slave acknowledge.
- wb_dat_i  in  dw  read data.

Behaviour:
- Interface decision: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE. This includes busy_o, done_o, err_cnt_o, first_err_addr_o, timeout_o and all wb_* outputs.
- Reset mid-burst: cyc/stb drop at the next edge. There is no graceful termination.
- FSM states: IDLE, WR, GAP, RD, FIN.
- IDLE:
  - start_i=1 captures mode_i, base_addr_i, burst_len_i and seed_i.
  - Clears err_cnt_o, first_err_addr_o and timeout_o.
  - Goes to WR for modes 00/01/11; goes to RD for mode 10.
  - start_i while not in IDLE is ignored.
- Latency: start accepted at edge N → cyc=stb=1 with beat 0 valid after edge N+1.
- WR and RD:
  - cyc=stb=1, sel all ones; we=1 in WR, 0 in RD.
  - Beat k (0-based) uses addr = base + k*(dw/8), modulo 2**APP_AW (wraps silently).
  - Pattern: data_k = seed + k, modulo 2**dw.
  - Beat advances only on a cycle with wb_ack_i=1. Addr, data and CTI for beat k+1 appear in the next cycle; stb stays high (no idle between beats).
  - cti = 3'b010 on all beats except the last, which is 3'b111. A single-beat burst is 3'b111 only.
  - An ack on the last beat leaves the state: WR → GAP (mode 00) or WR → FIN (mode 01); RD → FIN.
- GAP: exactly one cycle with cyc=stb=0, then RD with the beat index reset to 0.
- RD compare:
  - On ack, compare wb_dat_i against data_k.
  - On mismatch, err_cnt_o increments (saturating).
  - On the first mismatch only, first_err_addr_o takes the beat address.
- FIN: cyc=stb=we=0, cti=0; done_o=1 for this one cycle, busy_o=0 in the same cycle; return to IDLE.
- Bus state outside WR/RD: wb_addr_o and wb_dat_o hold their last values; they are don't-care.
- wb_ack_i outside WR/RD is ignored.
- start_i in the FIN cycle is ignored. The earliest new start is accepted the cycle after done_o.

Optional Feature:
- Macro: WB_BURST_TRAFFIC_GEN_TIMEOUT_EN.
- When defined:
  - A counter clears on every ack and on entry to WR/RD, and increments each WR/RD cycle without ack.
  - When the counter reaches TO_CYCLES-1 with no ack, the FSM drops cyc/stb next edge, sets timeout_o=1 and goes to FIN.
  - timeout_o holds until the next accepted start or reset.
- When undefined: no counter; timeout_o is tied 0; the FSM waits for ack indefinitely.

Decomposition:
- Package wb_burst_pkg holds:
  - the state enum;
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111;
  - mode constants MODE_WR_RD, MODE_WR, MODE_RD.
- One sub-module, wb_burst_beat_ctr: beat counter and address/data generator.
  - Inputs: load, inc, base, seed, length.
  - Outputs: addr, data, last.
  - Keeps the pattern/address arithmetic separate from the FSM.

Test Plan:
- Mode 00, base 0x100, len 4, seed 0xA5A50000, zero-wait slave acking every stb cycle:
  - writes 0xA5A50000..0xA5A50003 to 0x100/104/108/10C, CTI 010,010,010,111;
  - then one GAP cycle, then a matching read;
  - err_cnt=0, one done pulse.
- Same read, slave corrupts beat 2 (returns 0): err_cnt=1, first_err_addr=0x108.
- Mode 01, len 1, slave inserts 3 wait states: single beat with CTI 111 held until ack; done 1 cycle after ack; no read phase.
- len 0 (MAX_BL_W=8), base 0x3FFFFFC:
  - 256 beats;
  - address wraps to 0x0000000 on beat 1;
  - last beat CTI 111 at addr 0x00003F8.
- wb_rst_i asserted mid-RD burst: cyc/stb/busy_o 0 after next edge; start_i accepted the cycle after reset release.
- With WB_BURST_TRAFFIC_GEN_TIMEOUT_EN and TO_CYCLES=16, slave never acks:
  - cyc drops after 16 stb cycles;
  - timeout_o=1, done pulse;
  - next start clears timeout_o.

Source files
------------

// File: rtl/wb_burst_pkg.sv
// rtl/wb_burst_pkg.sv - shared state, CTI and mode encodings for the Wishbone burst generator
package wb_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_GAP,
        ST_RD,
        ST_FIN
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] MODE_WR_RD = 2'b00;
    localparam logic [1:0] MODE_WR    = 2'b01;
    localparam logic [1:0] MODE_RD    = 2'b10;

endpackage

// File: rtl/wb_burst_beat_ctr.sv
// rtl/wb_burst_beat_ctr.sv - beat index, incrementing byte address and seed+k data pattern
module wb_burst_beat_ctr #(
    parameter int DW  = 32,
    parameter int AW  = 26,
    parameter int BLW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] base,
    input  logic [DW-1:0] seed,
    input  logic [BLW-1:0] length,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          last
);

    localparam logic [AW-1:0] STEP = AW'(DW / 8);

    logic [BLW-1:0] idx_q, idx_d;
    logic [BLW-1:0] len_m1_q, len_m1_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;

    // length 0 wraps to all ones here, giving the full 2**BLW beats
    always_comb begin
        idx_d    = idx_q;
        len_m1_d = len_m1_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (load) begin
            idx_d    = '0;
            len_m1_d = length - 1'b1;
            addr_d   = base;
            data_d   = seed;
        end else if (inc) begin
            idx_d  = idx_q + 1'b1;
            addr_d = addr_q + STEP;
            data_d = data_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            len_m1_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            idx_q    <= idx_d;
            len_m1_q <= len_m1_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign addr = addr_q;
    assign data = data_q;
    assign last = (idx_q == len_m1_q);

endmodule

// File: rtl/wb_burst_traffic_gen.sv
// rtl/wb_burst_traffic_gen.sv - Wishbone B3 incrementing-burst master with read-back self-check
// Optional ack timeout abort: WB_BURST_TRAFFIC_GEN_TIMEOUT_EN
module wb_burst_traffic_gen
    import wb_burst_pkg::*;
#(
    parameter int dw        = 32,
    parameter int APP_AW    = 26,
    parameter int MAX_BL_W  = 8,
    parameter int TO_CYCLES = 1024
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start_i,
    input  logic [1:0]          mode_i,
    input  logic [APP_AW-1:0]   base_addr_i,
    input  logic [MAX_BL_W-1:0] burst_len_i,
    input  logic [dw-1:0]       seed_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [15:0]         err_cnt_o,
    output logic [APP_AW-1:0]   first_err_addr_o,
    output logic                timeout_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [APP_AW-1:0]   wb_addr_o,
    output logic [dw-1:0]       wb_dat_o,
    output logic [dw/8-1:0]     wb_sel_o,
    output logic [2:0]          wb_cti_o,
    input  logic                wb_ack_i,
    input  logic [dw-1:0]       wb_dat_i
);

    state_e                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [APP_AW-1:0]     base_q, base_d;
    logic [dw-1:0]         seed_q, seed_d;
    logic [MAX_BL_W-1:0]   len_q, len_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic [APP_AW-1:0]     first_err_q, first_err_d;

    logic                  ctr_load, ctr_inc, ctr_last;
    logic [APP_AW-1:0]     ld_base, ctr_addr;
    logic [dw-1:0]         ld_seed, ctr_data;
    logic [MAX_BL_W-1:0]   ld_len;
    logic                  bus_act;

`ifdef WB_BURST_TRAFFIC_GEN_TIMEOUT_EN
    localparam int TO_W = ($clog2(TO_CYCLES) > 0) ? $clog2(TO_CYCLES) : 1;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        base_d      = base_q;
        seed_d      = seed_q;
        len_d       = len_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        ctr_load    = 1'b0;
        ctr_inc     = 1'b0;
        ld_base     = base_q;
        ld_seed     = seed_q;
        ld_len      = len_q;
`ifdef WB_BURST_TRAFFIC_GEN_TIMEOUT_EN
        timeout_d   = timeout_q;
        to_cnt_d    = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                // counter loads straight from the ports so beat 0 is on the bus one edge after start
                ld_base = base_addr_i;
                ld_seed = seed_i;
                ld_len  = burst_len_i;
                if (start_i) begin
                    mode_d      = (mode_i == MODE_RD) ? MODE_RD :
                                  (mode_i == MODE_WR) ? MODE_WR : MODE_WR_RD;
                    base_d      = base_addr_i;
                    seed_d      = seed_i;
                    len_d       = burst_len_i;
                    err_cnt_d   = '0;
                    first_err_d = '0;
`ifdef WB_BURST_TRAFFIC_GEN_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                    ctr_load    = 1'b1;
                    state_d     = (mode_i == MODE_RD) ? ST_RD : ST_WR;
                end
            end
            ST_WR, ST_RD: begin
                if (wb_ack_i) begin
                    if (state_q == ST_RD && wb_dat_i != ctr_data) begin
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        if (err_cnt_q == 16'd0)    first_err_d = ctr_addr;
                    end
                    if (ctr_last) begin
                        if (state_q == ST_RD || mode_q == MODE_WR) state_d = ST_FIN;
                        else                                       state_d = ST_GAP;
                    end else begin
                        ctr_inc = 1'b1;
                    end
                end
`ifdef WB_BURST_TRAFFIC_GEN_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                ctr_load = 1'b1;
                state_d  = ST_RD;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            base_q      <= '0;
            seed_q      <= '0;
            len_q       <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
`ifdef WB_BURST_TRAFFIC_GEN_TIMEOUT_EN
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            seed_q      <= seed_d;
            len_q       <= len_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
`ifdef WB_BURST_TRAFFIC_GEN_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    wb_burst_beat_ctr #(
        .DW  (dw),
        .AW  (APP_AW),
        .BLW (MAX_BL_W)
    ) u_beat_ctr (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .load   (ctr_load),
        .inc    (ctr_inc),
        .base   (ld_base),
        .seed   (ld_seed),
        .length (ld_len),
        .addr   (ctr_addr),
        .data   (ctr_data),
        .last   (ctr_last)
    );

    assign bus_act          = (state_q == ST_WR) || (state_q == ST_RD);
    assign wb_cyc_o         = bus_act;
    assign wb_stb_o         = bus_act;
    assign wb_we_o          = (state_q == ST_WR);
    assign wb_sel_o         = {(dw/8){bus_act}};
    assign wb_cti_o         = bus_act ? (ctr_last ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
    assign wb_addr_o        = ctr_addr;
    assign wb_dat_o         = ctr_data;
    assign busy_o           = bus_act || (state_q == ST_GAP);
    assign done_o           = (state_q == ST_FIN);
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;
`ifdef WB_BURST_TRAFFIC_GEN_TIMEOUT_EN
    assign timeout_o        = timeout_q;
`else
    assign timeout_o        = 1'b0;
`endif

endmodule
